// File: rtl/cdb_arbiter_if.sv
// Common Data Bus bundle: functional-unit requests toward the arbiter and the
// registered broadcast back to the register file and reservation stations.
interface cdb_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 4
);
    localparam int unsigned PW = $clog2(N);

    logic            freeze;
    logic [N-1:0]    require;
    logic [N*DW-1:0] dataIn;
    logic [N*LW-1:0] labelIn;
    logic [N-1:0]    requireAC;
    logic            BCEN;
    logic [LW-1:0]   BClabel;
    logic [DW-1:0]   BCdata;
    logic [PW-1:0]   lastGrant;
    logic            protoErr;

    // Functional units and consumers
    modport master (
        output freeze, require, dataIn, labelIn,
        input  requireAC, BCEN, BClabel, BCdata, lastGrant, protoErr
    );

    // Arbiter
    modport slave (
        input  freeze, require, dataIn, labelIn,
        output requireAC, BCEN, BClabel, BCdata, lastGrant, protoErr
    );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter: one grant per cycle, combinational accept in the
// request cycle, broadcast registered for the following cycle.
module cdb_arbiter #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 32,
    parameter int unsigned LW = 4
) (
    input  logic          clk,
    input  logic          RST,
    cdb_arbiter_if.slave  bus
);
    localparam int unsigned PW = $clog2(N);

    logic [PW-1:0] ptr;
    logic [PW-1:0] winner;
    logic [PW-1:0] idx;
    logic          grant;
    logic [LW-1:0] win_label;
    logic [DW-1:0] win_data;
    logic [PW-1:0] ptr_next;

    // Search from ptr with wrap; reset and freeze suppress any grant
    always_comb begin
        grant         = 1'b0;
        winner        = '0;
        idx           = '0;
        bus.requireAC = '0;
        if (!RST && !bus.freeze) begin
            for (int unsigned k = 0; k < N; k++) begin
                idx = PW'((32'(ptr) + k) % N);
                if (!grant && bus.require[idx]) begin
                    grant  = 1'b1;
                    winner = idx;
                end
            end
        end
        if (grant) begin
            bus.requireAC[winner] = 1'b1;
        end
    end

    always_comb begin
        win_label = bus.labelIn[32'(winner) * LW +: LW];
        win_data  = bus.dataIn[32'(winner) * DW +: DW];
        ptr_next  = PW'((32'(winner) + 32'd1) % N);
    end

    // Label 0 still drains the unit but never reaches consumers as valid
    always_ff @(posedge clk) begin
        if (RST) begin
            ptr           <= '0;
            bus.BCEN      <= 1'b0;
            bus.BClabel   <= '0;
            bus.BCdata    <= '0;
            bus.lastGrant <= '0;
            bus.protoErr  <= 1'b0;
        end else if (grant) begin
            ptr           <= ptr_next;
            bus.lastGrant <= winner;
            bus.BClabel   <= win_label;
            bus.BCdata    <= win_data;
            bus.BCEN      <= (win_label != '0);
            if (win_label == '0) begin
                bus.protoErr <= 1'b1;
            end
        end else begin
            bus.BCEN <= 1'b0;
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed self-checking bench for cdb_arbiter.
module tb_cdb_arbiter;
    localparam int unsigned N  = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned LW = 4;

    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    cdb_arbiter_if #(.N(N), .DW(DW), .LW(LW)) bus ();

    cdb_arbiter #(.N(N), .DW(DW), .LW(LW)) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int i, input logic [LW-1:0] l, input logic [DW-1:0] d);
        bus.labelIn[i*LW +: LW] = l;
        bus.dataIn[i*DW +: DW]  = d;
    endtask

    initial begin
        rst        = 1'b1;
        bus.freeze = 1'b0;
        bus.require = '0;
        bus.dataIn  = '0;
        bus.labelIn = '0;
        step();
        bus.require = 4'hF;
        #1;
        check("rst_ac", 64'(bus.requireAC), 64'h0);
        step();
        check("rst_bcen", 64'(bus.BCEN), 64'h0);
        check("rst_label", 64'(bus.BClabel), 64'h0);
        check("rst_data", 64'(bus.BCdata), 64'h0);
        check("rst_last", 64'(bus.lastGrant), 64'h0);
        check("rst_perr", 64'(bus.protoErr), 64'h0);
        bus.require = '0;
        rst = 1'b0;
        step();

        // 1: single request from port 1
        set_port(1, 4'd5, 32'h0000_00AA);
        bus.require = 4'b0010;
        #1;
        check("t1_ac", 64'(bus.requireAC), 64'h2);
        step();
        check("t1_bcen", 64'(bus.BCEN), 64'h1);
        check("t1_label", 64'(bus.BClabel), 64'h5);
        check("t1_data", 64'(bus.BCdata), 64'hAA);
        check("t1_last", 64'(bus.lastGrant), 64'h1);
        check("t1_ptr", 64'(dut.ptr), 64'h2);
        bus.require = '0;
        step();
        check("t1_idle_bcen", 64'(bus.BCEN), 64'h0);
        check("t1_hold_label", 64'(bus.BClabel), 64'h5);

        // 2: all ports continuously requesting, from ptr 0
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) set_port(k, LW'(k + 1), 32'h100 + 32'(k));
        bus.require = 4'hF;
        for (int k = 0; k < 4; k++) begin
            #1;
            check("t2_ac", 64'(bus.requireAC), 64'(1) << k);
            step();
            check("t2_bcen", 64'(bus.BCEN), 64'h1);
            check("t2_label", 64'(bus.BClabel), 64'(k + 1));
            check("t2_data", 64'(bus.BCdata), 64'h100 + 64'(k));
            check("t2_last", 64'(bus.lastGrant), 64'(k));
        end
        #1;
        check("t2_wrap_ac", 64'(bus.requireAC), 64'h1);
        step();
        bus.require = '0;
        step();

        // 3: wrap-around from ptr 3 (port 2 grant moves ptr to 3)
        bus.require = 4'b0100;
        step();
        set_port(0, 4'd7, 32'h7777);
        set_port(3, 4'd9, 32'h9999);
        bus.require = 4'b1001;
        #1;
        check("t3_ac3", 64'(bus.requireAC), 64'h8);
        step();
        check("t3_label3", 64'(bus.BClabel), 64'h9);
        check("t3_last3", 64'(bus.lastGrant), 64'h3);
        bus.require = 4'b0001;
        #1;
        check("t3_ac0", 64'(bus.requireAC), 64'h1);
        step();
        check("t3_label0", 64'(bus.BClabel), 64'h7);
        check("t3_last0", 64'(bus.lastGrant), 64'h0);
        check("t3_data0", 64'(bus.BCdata), 64'h7777);

        // 4: label 0 protocol error, ptr now 1
        set_port(2, 4'd0, 32'hDEAD);
        bus.require = 4'b0100;
        #1;
        check("t4_ac", 64'(bus.requireAC), 64'h4);
        step();
        check("t4_bcen", 64'(bus.BCEN), 64'h0);
        check("t4_perr", 64'(bus.protoErr), 64'h1);
        check("t4_last", 64'(bus.lastGrant), 64'h2);
        set_port(1, 4'd6, 32'h6666);
        bus.require = 4'b0010;
        step();
        check("t4_valid_bcen", 64'(bus.BCEN), 64'h1);
        check("t4_perr_sticky", 64'(bus.protoErr), 64'h1);

        // 5: freeze for three cycles while port 0 requests
        set_port(0, 4'd8, 32'h55);
        bus.require = 4'b0001;
        bus.freeze  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t5_frz_ac", 64'(bus.requireAC), 64'h0);
            step();
            check("t5_frz_bcen", 64'(bus.BCEN), 64'h0);
        end
        bus.freeze = 1'b0;
        #1;
        check("t5_ac", 64'(bus.requireAC), 64'h1);
        step();
        check("t5_bcen", 64'(bus.BCEN), 64'h1);
        check("t5_label", 64'(bus.BClabel), 64'h8);
        check("t5_data", 64'(bus.BCdata), 64'h55);
        check("t5_last", 64'(bus.lastGrant), 64'h0);
        bus.require = '0;

        // 6: reset in the middle of a grant stream, ptr now 1
        for (int k = 0; k < 4; k++) set_port(k, LW'(k + 1), 32'h200 + 32'(k));
        bus.require = 4'hF;
        step();
        check("t6_last1", 64'(bus.lastGrant), 64'h1);
        step();
        check("t6_last2", 64'(bus.lastGrant), 64'h2);
        rst = 1'b1;
        #1;
        check("t6_rst_ac", 64'(bus.requireAC), 64'h0);
        step();
        check("t6_rst_bcen", 64'(bus.BCEN), 64'h0);
        check("t6_rst_label", 64'(bus.BClabel), 64'h0);
        check("t6_rst_data", 64'(bus.BCdata), 64'h0);
        check("t6_rst_last", 64'(bus.lastGrant), 64'h0);
        check("t6_rst_perr", 64'(bus.protoErr), 64'h0);
        check("t6_rst_ptr", 64'(dut.ptr), 64'h0);
        rst = 1'b0;
        #1;
        check("t6_restart_ac", 64'(bus.requireAC), 64'h1);
        step();
        check("t6_restart_last", 64'(bus.lastGrant), 64'h0);
        check("t6_restart_label", 64'(bus.BClabel), 64'h1);
        bus.require = '0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Sequential round-robin arbiter and broadcast register for the Common Data Bus. It accepts completed results from up to four functional-unit ports (0 ALU, 1 MUL, 2 DIV, 3 LS) and grants one port per cycle. The granted result is registered and broadcast on `BCEN`/`BClabel`/`BCdata` to the register file and every reservation station. It replaces the fixed-priority combinational CDBHelper/CDB pair, so no unit can starve.

## Interface
- `N`, 4: number of requesting ports; the pointer is `log2(N)` bits wide.
- `DW`, 32: result data width.
- `LW`, 4: tag (label) width. Label 0 is reserved and means "no producer".

- `clk`  in  1  rising-edge clock.
- `RST`  in  1  reset; synchronous, active-high.
- `freeze`  in  1  when high, no grants are issued and the pointer holds.
- `require`  in  N  per-port request. The port holds it high until it sees its accept.
- `dataIn`  in  N*DW  per-port result; port i occupies bits [i*DW +: DW].
- `labelIn`  in  N*LW  per-port tag; port i occupies bits [i*LW +: LW].
- `requireAC`  out  N  one-hot accept, combinational in the request cycle.
- `BCEN`  out  1  broadcast valid, registered.
- `BClabel`  out  LW  broadcast tag, registered.
- `BCdata`  out  DW  broadcast data, registered.
- `lastGrant`  out  log2(N)  index of the most recent grant, registered.
- `protoErr`  out  1  sticky flag: a request carried label 0.

## Operation
- Priority pointer `ptr`:
  - The search starts at port `ptr` and wraps modulo N.
  - The first port with `require` high wins and gets `requireAC` high.
  - On a grant, `ptr` becomes (winner+1) mod N; 3 wraps to 0.
  - With no grant, `ptr` holds.
- `requireAC` is zero whenever `freeze` or `RST` is high, or `require` is all zero.
- `requireAC` has at most one bit set.
- Grant, broadcast path: on the clock edge closing a grant cycle, the arbiter loads the winner's `dataIn`/`labelIn` into `BCdata`/`BClabel` and sets `BCEN` to 1.
- Grant carrying label 0:
  - The grant and accept are still issued, so the unit drains and cannot deadlock.
  - `BCEN` stays 0 for that broadcast.
  - `protoErr` sets and stays set until reset.
- No grant in a cycle: the next cycle has `BCEN` = 0. `BClabel` and `BCdata` hold their previous values, which consumers ignore.
- Freeze:
  - `freeze` blocks new grants only.
  - A broadcast already registered still appears on its cycle.
  - Requests stay pending, untouched, until `freeze` drops.

## Timing
- Reset values on the edge where `RST` is high:
  - `ptr` = 0, `BCEN` = 0, `BClabel` = 0, `BCdata` = 0, `lastGrant` = 0, `protoErr` = 0.
  - `requireAC` = 0 combinationally while `RST` is high.
- Reset mid-operation discards any pending grant. Ports still requesting are re-arbitrated from port 0 after `RST` falls.
- Latency: request in cycle t, accept in cycle t, broadcast visible in cycle t+1 for exactly one cycle.
- Handshake rules:
  - A port must keep `require`, `dataIn` and `labelIn` stable until it samples `requireAC` high.
  - The port deasserts `require` (or presents its next result) from cycle t+1.
- Throughput: one broadcast per cycle. With all four ports requesting continuously, grants run in the order 0,1,2,3,0… on back-to-back cycles.
- Simultaneous events: `freeze` rising in the same cycle as a request blocks that request. This is decided combinationally, with no partial grant.

## Test plan
1. Reset, then port 1 requests with label 5, data 0x0000_00AA.
   - `requireAC` = 0010 in the same cycle.
   - Next cycle: `BCEN` = 1, `BClabel` = 5, `BCdata` = 0xAA, `lastGrant` = 1, and `ptr` becomes 2.
2. All four ports hold `require` high, labels 1–4.
   - Grants go 0,1,2,3 on four consecutive cycles.
   - `BCEN` stays 1 throughout, and `BClabel` sequence is 1,2,3,4.
3. With `ptr` = 3, ports 0 and 3 request.
   - Port 3 wins first, then port 0 on the next cycle (wrap-around check).
4. Port 2 requests with label 0.
   - `requireAC` = 0100.
   - Next cycle: `BCEN` = 0 and `protoErr` = 1.
   - `protoErr` remains 1 after later valid broadcasts until `RST`.
5. `freeze` is high for 3 cycles while port 0 requests.
   - `requireAC` = 0 and `BCEN` = 0 during the freeze.
   - First cycle after `freeze` falls: grant to port 0, broadcast on the following cycle.
6. Assert `RST` during a stream of grants.
   - The next cycle shows all outputs at reset values.
   - After release, arbitration restarts at port 0.
